gate_truth_table_analyzer: RTL and testbench
============================================

Name: gate_truth_table_analyzer

Overview:
Sequential characteriser that drives the two inputs of a 2-input logic-gate DUT and reads back its single output. It steps through all four input combinations, captures the 4-bit truth table, and classifies it as one of AND, OR, NOT(a), NAND, NOR, XOR or XNOR, or as unknown. It sits on the stimulus/response side of the gate-level primitives and serves as the self-check block for on-board and bench gate demos.

Parameters:
SETTLE_CYCLES, 2, cycles each input combination is held before dut_out is sampled; legal range 1..255.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a characterisation run
dut_out  input  1  output of the gate under test
drive_a  output  1  input a driven to the DUT
drive_b  output  1  input b driven to the DUT
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse when results are updated
truth_table  output  4  captured responses, bit index = {a,b}, so bit3 = f(1,1)
gate_id  output  3  classification code; codes listed in Decomposition
known  output  1  1 when gate_id is not UNKNOWN

Behaviour:
- Clocking and reset are fixed: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: drive_a=0, drive_b=0, busy=0, done=0, truth_table=0, gate_id=0 (UNKNOWN), known=0. State is IDLE, combo index is 0 and the settle counter is 0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE: on a rising edge with start=1, go to SETTLE. Set combo index to 0, drive {a,b}=00, load the counter with SETTLE_CYCLES-1, and set busy=1.
- SETTLE: each {a,b} value is held for exactly SETTLE_CYCLES cycles.
  - The counter decrements each cycle.
  - On the edge where the counter is 0, dut_out is written into the scratch truth-table bit selected by the combo index.
  - If the index is less than 3, the index increments, drive_a/drive_b move to the next combination (00, 01, 10, 11 in that order, drive_a = index[1], drive_b = index[0]) and the counter reloads.
  - If the index is 3, go to DONE.
- DONE lasts one cycle, with outputs registered on the edge that enters it:
  - truth_table, gate_id and known are updated; done=1; busy=0.
  - drive_a and drive_b return to 0.
  - Next state is IDLE, or SETTLE if start=1 in that cycle.
- Latency: done is high in the cycle after the 4*SETTLE_CYCLES-th rising edge following the start-accept edge. With SETTLE_CYCLES=2, start is accepted at edge 0, samples are taken at edges 2, 4, 6 and 8, and done is high during cycle 9.
- start while busy=1 is ignored; no queuing.
- truth_table, gate_id and known hold their values between runs. They change only in the DONE update or on reset.
- Decode (truth_table -> gate_id):
  - 1000 -> AND (1)
  - 1110 -> OR (2)
  - 0011 -> NOT_A (3)
  - 0111 -> NAND (4)
  - 1001 -> NOR (5)

    Correction: NOR is 0001, and 1001 is XNOR. The full table follows.
  - 0001 -> NOR (5)
  - 0110 -> XOR (6)
  - 1001 -> XNOR (7)
  - any other value -> UNKNOWN (0), with known=0
- Reset mid-run: the run is abandoned immediately, all outputs return to their reset values, and no done pulse is produced.
- dut_out is treated as synchronous to clk; the block does no synchronisation.

Decomposition:
- Shared package gate_pkg:
  - gate_id_t enum: UNKNOWN=0, AND=1, OR=2, NOT_A=3, NAND=4, NOR=5, XOR=6, XNOR=7.
  - Truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_NOT_A=4'b0011, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- One natural sub-module, gate_tt_decode: purely combinational mapping from the 4-bit truth table to gate_id and known. It is instantiated once, on the scratch register, feeding the DONE update.

Test Plan:
- Reset then idle: assert rst for 3 cycles, hold start=0 for 20 cycles -> all outputs stay 0; drive_a and drive_b stay 0.
- AND DUT (dut_out = drive_a & drive_b), SETTLE_CYCLES=2, pulse start -> drive sequence 00,01,10,11 with 2 cycles each; done high in cycle 9; truth_table=1000, gate_id=1, known=1.
- XNOR DUT -> truth_table=1001, gate_id=7. NOT(a) DUT -> truth_table=0011, gate_id=3.
- Constant dut_out=1 -> truth_table=1111, gate_id=0, known=0.
- Busy and back-to-back runs: with an XOR DUT, pulse start again at cycle 4 -> ignored; done occurs exactly once in cycle 9 with gate_id=6. Start in the DONE cycle -> a new run begins with drive 00 in the next cycle.
- Reset mid-run: assert rst at cycle 5 of an OR run -> outputs are 0 immediately and no done pulse follows. A new start with an OR DUT then gives truth_table=1110, gate_id=2.

Source files
------------

// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_pkg
// Description : Shared gate classification codes and reference truth tables
//               for the gate truth-table analyzer. Truth-table bit index is
//               {a,b}, so bit3 holds f(1,1).
// Revision    : 1.0 - initial release
// ============================================================================
package gate_pkg;

    typedef enum logic [2:0] {
        UNKNOWN = 3'd0,
        AND     = 3'd1,
        OR      = 3'd2,
        NOT_A   = 3'd3,
        NAND    = 3'd4,
        NOR     = 3'd5,
        XOR     = 3'd6,
        XNOR    = 3'd7
    } gate_id_t;

    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_NOT_A = 4'b0011;
    localparam logic [3:0] TT_NAND  = 4'b0111;
    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_XNOR  = 4'b1001;

endpackage : gate_pkg
`default_nettype wire

// File: rtl/gate_tt_decode.sv
`default_nettype none
// ============================================================================
// Module      : gate_tt_decode
// Description : Combinational classifier from a 4-bit truth table to a gate
//               code plus a flag saying whether the gate was recognised.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_tt_decode
    import gate_pkg::*;
(
    input  logic [3:0] truth_table,
    output logic [2:0] gate_id,
    output logic       known
);

    gate_id_t w_id;

    // Match the captured table against each reference pattern
    always_comb begin
        w_id = UNKNOWN;
        case (truth_table)
            TT_AND:   w_id = AND;
            TT_OR:    w_id = OR;
            TT_NOT_A: w_id = NOT_A;
            TT_NAND:  w_id = NAND;
            TT_NOR:   w_id = NOR;
            TT_XOR:   w_id = XOR;
            TT_XNOR:  w_id = XNOR;
            default:  w_id = UNKNOWN;
        endcase
    end

    assign gate_id = w_id;
    assign known   = (w_id != UNKNOWN);

endmodule : gate_tt_decode
`default_nettype wire

// File: rtl/gate_truth_table_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_table_analyzer
// Description : Steps a 2-input gate through 00,01,10,11, holds each
//               combination SETTLE_CYCLES cycles, samples the gate output on
//               the last cycle, then publishes the truth table and its
//               classification with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_truth_table_analyzer
    import gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       drive_a,
    output logic       drive_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic [2:0] gate_id,
    output logic       known
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Counter counts down to zero, so a combo lasts RELOAD+1 = SETTLE_CYCLES
    localparam logic [7:0] c_RELOAD = 8'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] r_idx;
    logic [7:0] r_cnt;
    logic [3:0] r_scratch;
    logic       r_drive_a;
    logic       r_drive_b;
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_truth_table;
    logic [2:0] r_gate_id;
    logic       r_known;

    logic [3:0] w_scratch_next;
    logic [1:0] w_idx_next;
    logic [2:0] w_gate_id;
    logic       w_known;

    // Scratch table with the sample being captured this edge merged in, so
    // the final classification sees all four responses on the DONE-entry edge
    always_comb begin
        w_scratch_next        = r_scratch;
        w_scratch_next[r_idx] = dut_out;
    end

    assign w_idx_next = r_idx + 2'd1;

    gate_tt_decode u_decode (
        .truth_table (w_scratch_next),
        .gate_id     (w_gate_id),
        .known       (w_known)
    );

    // Run sequencer: drive combos, sample responses, publish results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= 2'd0;
            r_cnt         <= 8'd0;
            r_scratch     <= 4'd0;
            r_drive_a     <= 1'b0;
            r_drive_b     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_truth_table <= 4'd0;
            r_gate_id     <= 3'd0;
            r_known       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state   <= S_SETTLE;
                        r_idx     <= 2'd0;
                        r_cnt     <= c_RELOAD;
                        r_scratch <= 4'd0;
                        r_drive_a <= 1'b0;
                        r_drive_b <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_scratch <= w_scratch_next;
                        if (r_idx != 2'd3) begin
                            r_idx     <= w_idx_next;
                            r_drive_a <= w_idx_next[1];
                            r_drive_b <= w_idx_next[0];
                            r_cnt     <= c_RELOAD;
                        end else begin
                            r_state       <= S_DONE;
                            r_truth_table <= w_scratch_next;
                            r_gate_id     <= w_gate_id;
                            r_known       <= w_known;
                            r_done        <= 1'b1;
                            r_busy        <= 1'b0;
                            r_drive_a     <= 1'b0;
                            r_drive_b     <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state   <= S_SETTLE;
                        r_idx     <= 2'd0;
                        r_cnt     <= c_RELOAD;
                        r_scratch <= 4'd0;
                        r_drive_a <= 1'b0;
                        r_drive_b <= 1'b0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign drive_a     = r_drive_a;
    assign drive_b     = r_drive_b;
    assign busy        = r_busy;
    assign done        = r_done;
    assign truth_table = r_truth_table;
    assign gate_id     = r_gate_id;
    assign known       = r_known;

endmodule : gate_truth_table_analyzer
`default_nettype wire

// File: tb/tb_gate_truth_table_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_truth_table_analyzer
// Description : Scoreboard bench for the gate truth-table analyzer. A model
//               gate responds to drive_a/drive_b; each run pushes its
//               hand-computed result and a negedge monitor pops on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_truth_table_analyzer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dut_out;
    logic       drive_a;
    logic       drive_b;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [2:0] gate_id;
    logic       known;

    int n_pass;
    int n_total;
    int done_count;
    int gate_sel;

    // expected result packed as {truth_table, gate_id, known}
    logic [7:0] exp_q[$];

    gate_truth_table_analyzer #(.SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dut_out     (dut_out),
        .drive_a     (drive_a),
        .drive_b     (drive_b),
        .busy        (busy),
        .done        (done),
        .truth_table (truth_table),
        .gate_id     (gate_id),
        .known       (known)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model gate under test
    always_comb begin
        case (gate_sel)
            0: dut_out = drive_a & drive_b;
            1: dut_out = ~(drive_a ^ drive_b);
            2: dut_out = ~drive_a;
            3: dut_out = 1'b1;
            4: dut_out = drive_a ^ drive_b;
            5: dut_out = drive_a | drive_b;
            default: dut_out = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", {24'd0, truth_table, gate_id, known}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("result", {24'd0, truth_table, gate_id, known}, {24'd0, e});
            end
        end
    end

    // Pulse start so it is sampled by the next edge; returns #1 after that edge
    task automatic issue_start(input int gsel, input logic [7:0] exp_res, input bit push);
        gate_sel = gsel;
        start    = 1'b1;
        if (push) exp_q.push_back(exp_res);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called #1 after the start-accept edge; ends #1 after the DONE-entry edge
    task automatic run_body(input int extra_start_k);
        for (int k = 0; k < 8; k++) begin
            int c;
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            c = k / 2;
            check($sformatf("drive_k%0d", k), {28'd0, drive_a, drive_b, busy, done},
                  {28'd0, c[1], c[0], 1'b1, 1'b0});
            if (k == extra_start_k) start = 1'b1;
            if (k == extra_start_k + 1) start = 1'b0;
        end
        @(posedge clk);
        #1;
        check("done_phase", {28'd0, drive_a, drive_b, busy, done}, 32'b0001);
    endtask

    initial begin
        int dc;
        n_pass = 0; n_total = 0; done_count = 0; gate_sel = 0;
        rst = 1'b1; start = 1'b0;

        // Reset, then idle with start low
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {21'd0, drive_a, drive_b, busy, done, truth_table, gate_id, known}, 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle_outputs", {21'd0, drive_a, drive_b, busy, done, truth_table, gate_id, known}, 32'd0);
        end

        // AND, XNOR, constant-1
        issue_start(0, {4'b1000, 3'd1, 1'b1}, 1'b1); run_body(-1);
        repeat (3) @(posedge clk);
        #1 check("hold_after_and", {24'd0, truth_table, gate_id, known}, {24'd0, 4'b1000, 3'd1, 1'b1});
        issue_start(1, {4'b1001, 3'd7, 1'b1}, 1'b1); run_body(-1);
        repeat (2) @(posedge clk);
        #1;
        issue_start(3, {4'b1111, 3'd0, 1'b0}, 1'b1); run_body(-1);
        repeat (2) @(posedge clk);
        #1;

        // XOR with a start during busy (ignored), then chained NOT_A from DONE
        dc = done_count;
        issue_start(4, {4'b0110, 3'd6, 1'b1}, 1'b1); run_body(3);
        issue_start(2, {4'b0011, 3'd3, 1'b1}, 1'b1);
        check("chain_drive00", {29'd0, drive_a, drive_b, busy}, 32'b001);
        check("xor_single_done", done_count, dc + 1);
        run_body(-1);
        repeat (4) @(posedge clk);
        #1 check("idle_after_chain", {30'd0, busy, done}, 32'd0);

        // OR run abandoned by reset mid-way
        dc = done_count;
        issue_start(5, 8'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("midrun_reset", {21'd0, drive_a, drive_b, busy, done, truth_table, gate_id, known}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (15) @(posedge clk);
        #1 check("no_done_after_reset", done_count, dc);

        // Fresh OR run
        issue_start(5, {4'b1110, 3'd2, 1'b1}, 1'b1); run_body(-1);
        repeat (3) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_gate_truth_table_analyzer
`default_nettype wire
